// File: rtl/reg_pkg.sv
// Shared definitions for loadable registers: default width/reset value and a
// reusable even-parity helper.
package reg_pkg;

   localparam int REG_DEFAULT_SIZE  = 8;
   localparam int REG_DEFAULT_RESET = 0;

   // Widest word the parity helper accepts; callers zero-extend narrower words.
   localparam int REG_PARITY_W = 256;

   function automatic logic parity(input logic [REG_PARITY_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/data_register.sv
// Clock-enabled storage register with asynchronous active-low reset.
// Optional macro REGISTER_PARITY_EN adds a registered even-parity output regParity.
module data_register
   import reg_pkg::*;
#(
   parameter int               size        = REG_DEFAULT_SIZE,
   parameter logic [size-1:0]  RESET_VALUE = size'(REG_DEFAULT_RESET)
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic [size-1:0] regIn,
   output logic [size-1:0] regOut
`ifdef REGISTER_PARITY_EN
   ,
   output logic            regParity
`endif
);

   logic [size-1:0] data_r;

   assign regOut = data_r;

`ifdef REGISTER_PARITY_EN
   localparam logic PARITY_RESET = parity(REG_PARITY_W'(RESET_VALUE));

   logic parity_r;
   logic parity_in_s;

   assign parity_in_s = parity(REG_PARITY_W'(regIn));
   assign regParity   = parity_r;

   // Storage for the data word and its parity; both load on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_r   <= RESET_VALUE;
         parity_r <= PARITY_RESET;
      end else if (enable) begin
         data_r   <= regIn;
         parity_r <= parity_in_s;
      end else begin
         data_r   <= data_r;
         parity_r <= parity_r;
      end
   end
`else
   // Storage for the data word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_r <= RESET_VALUE;
      end else if (enable) begin
         data_r <= regIn;
      end else begin
         data_r <= data_r;
      end
   end
`endif

endmodule

// File: tb/tb_data_register.sv
// Directed self-checking bench for data_register (size 8, plus a 4-bit
// instance with a non-zero reset value). Honours REGISTER_PARITY_EN.
module tb_data_register;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [7:0] regIn;
   logic [7:0] regOut;
   logic [3:0] regOut_w4;
`ifdef REGISTER_PARITY_EN
   logic       regParity;
   logic       regParity_w4;
`endif

   int checks   = 0;
   int failures = 0;

   data_register #(.size(8)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .regIn     (regIn),
      .regOut    (regOut)
`ifdef REGISTER_PARITY_EN
      ,
      .regParity (regParity)
`endif
   );

   data_register #(.size(4), .RESET_VALUE(4'hA)) u_dut_w4 (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .regIn     (regIn[3:0]),
      .regOut    (regOut_w4)
`ifdef REGISTER_PARITY_EN
      ,
      .regParity (regParity_w4)
`endif
   );

   initial clock = 1'b0;
   always #50 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      regIn  = 8'h00;

      // t=120: async reset with no clock edge
      #120 reset = 1'b0;
      #1;
      check("async_reset",    32'(regOut),    32'h00);
      check("async_reset_w4", 32'(regOut_w4), 32'hA);
`ifdef REGISTER_PARITY_EN
      check("async_reset_par",    32'(regParity),    32'h0);
      check("async_reset_par_w4", 32'(regParity_w4), 32'h0);
`endif
      enable = 1'b1;
      regIn  = 8'd97;

      // t=300: two edges in reset with enable high
      #179;
      check("hold_in_reset", 32'(regOut), 32'h00);
      reset  = 1'b1;
      enable = 1'b0;

      // t=500: two edges with enable low
      #200;
      check("enable_low", 32'(regOut), 32'h00);
      enable = 1'b1;

      // t=540: before the loading edge
      #40;
      check("no_early_load", 32'(regOut), 32'h00);

      // t=600: after the edge at 550
      #60;
      check("load_97", 32'(regOut), 32'd97);
`ifdef REGISTER_PARITY_EN
      check("load_97_par", 32'(regParity), 32'h1);
`endif
      enable = 1'b0;
      regIn  = 8'h00;

      // pulse enable between edges only
      #10 enable = 1'b1;
      regIn = 8'hAA;
      #30 enable = 1'b0;

      // t=700, t=800: value held
      #60;
      check("hold_97_a", 32'(regOut), 32'd97);
      #100;
      check("hold_97_b", 32'(regOut), 32'd97);

      // t=820: reset mid-cycle with a load pending
      #20;
      enable = 1'b1;
      regIn  = 8'h3C;
      reset  = 1'b0;
      #1;
      check("mid_reset", 32'(regOut), 32'h00);
`ifdef REGISTER_PARITY_EN
      check("mid_reset_par", 32'(regParity), 32'h0);
`endif

      // t=900: edge at 850 was in reset
      #79;
      check("reset_overrides_load", 32'(regOut), 32'h00);

      // release coincident with the edge at 950
      @(posedge clock);
      reset <= 1'b1;
      #50;
      check("release_edge_in_reset",    32'(regOut),    32'h00);
      check("release_edge_in_reset_w4", 32'(regOut_w4), 32'hA);

      // t=1100: first load after release
      #100;
      check("load_3c",    32'(regOut),    32'h3C);
      check("load_3c_w4", 32'(regOut_w4), 32'hC);
`ifdef REGISTER_PARITY_EN
      check("load_3c_par", 32'(regParity), 32'h0);
`endif
      regIn = 8'hFF;

      #100;
      check("load_ff", 32'(regOut), 32'hFF);
`ifdef REGISTER_PARITY_EN
      check("load_ff_par", 32'(regParity), 32'h0);
`endif
      regIn = 8'h01;

      #100;
      check("load_01", 32'(regOut), 32'h01);
`ifdef REGISTER_PARITY_EN
      check("load_01_par", 32'(regParity), 32'h1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
